t05_hist_sram_client: RTL
=========================

// Module: t05_hist_sram_client
// PURPOSE
// - Initiator side of the team SRAM request interface, used by the histogram stage.
// - Accepts one input character per handshake and reads its 32-bit count from SRAM
//   word {HIST_BASE, char}. It then writes back count+1 and raises done when EOF is reached.
// - Sits between the byte-stream front end and t05_sram.
// - Replaces the ad-hoc r_en/wr_en/histgram_addr driving with a real handshake.
// PARAMETERS
// - HIST_BASE  8'h00  upper address byte prepended to char (SRAM word = {HIST_BASE,char}).
// - DATA_W     32     histogram word width.
// - TIMEOUT    16     max wait cycles for a responder handshake before ERROR (>=2).
// PORTS
// - clk         in   1       system clock
// - rst         in   1       asynchronous, active-high reset
// - char_valid  in   1       input character valid
// - char_i      in   8       input character
// - eof_i       in   1       end of stream; level, held until done_o seen
// - char_ready  out  1       character accepted this cycle (char_valid & char_ready)
// - rd_en_o     out  1       read request to SRAM, held until ready_i
// - wr_en_o     out  1       write request to SRAM, held until !busy_i
// - addr_o      out  16      SRAM word address {HIST_BASE,char}
// - wr_data_o   out  DATA_W  value to write (read count + 1)
// - rd_data_i   in   DATA_W  read data from SRAM, valid when ready_i
// - ready_i     in   1       SRAM read data valid (1-cycle pulse)
// - busy_i      in   1       SRAM busy; a write is accepted on wr_en_o & !busy_i
// - total_o     out  32      number of characters committed to SRAM
// - done_o      out  1       histogram pass complete
// - error_o     out  1       handshake timeout; sticky until rst
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE; all outputs 0; total_o=0; timeout counter=0.
// - States:
//   - IDLE: char_ready=1.
//     - char_valid: latch char into addr_o, go to READ.
//     - else eof_i: go to DONE.
//     - char_valid has priority over eof_i in the same cycle. The char is processed,
//       then eof_i is re-sampled on return to IDLE.
//   - READ: rd_en_o=1, addr_o stable.
//     - ready_i: wr_data_o <= rd_data_i+1, go to WRITE.
//     - A same-cycle ready_i counts; no extra wait is needed.
//   - WRITE: wr_en_o=1, addr_o/wr_data_o stable.
//     - !busy_i: the write is accepted; total_o+=1, go to IDLE.
//   - DONE: done_o=1. Go to IDLE when eof_i drops. total_o is held; it is cleared only by rst.
//   - ERROR: error_o=1 and all requests 0. There is no exit except rst.
// - Timeout: a counter clears on entry to READ or WRITE and increments each cycle the
//   handshake is not met. On reaching TIMEOUT-1 without the handshake, go to ERROR.
// - Latency: 3 cycles per char minimum (accept, READ, WRITE). The next char can be
//   accepted on the 4th cycle.
// - rd_en_o and wr_en_o are never high together. They deassert the cycle after their handshake.
// - Arithmetic: count+1 is modulo 2^DATA_W (0xFFFFFFFF+1 -> 0) unless the option below is
//   enabled. total_o wraps modulo 2^32.
// - Stray ready_i outside READ is ignored. busy_i outside WRITE is ignored.
// - Repeated char: there is no bypass. Each char fully read-modify-writes before the next
//   one is accepted, so back-to-back identical chars are counted correctly.
// - rst mid-READ/WRITE: requests drop immediately. The SRAM word may or may not have been
//   written; no retry is made.
// CONFIGURATION
// - T05_HIST_SAT_EN defined: the increment saturates. rd_data_i==all-ones writes
//   all-ones back, and total_o still increments.
// - T05_HIST_SAT_EN undefined: the increment wraps to 0.
// TESTING
// - rst mid-stream -> all outputs 0 asynchronously; state IDLE; total_o=0.
// - char 8'h41, rd_data_i=5, ready_i/busy_i immediate:
//   -> addr_o=16'h0041, wr_data_o=6, total_o=1.
//   -> char_ready is high again 3 cycles after acceptance.
// - chars 41,41 back-to-back with a model SRAM starting at 0 -> final word[0x41]=2, total_o=2.
// - ready_i withheld for 16 cycles in READ with TIMEOUT=16 -> error_o=1 and
//   rd_en_o=0 by cycle 16; stays high until rst.
// - rd_data_i=32'hFFFF_FFFF -> wr_data_o=0 without T05_HIST_SAT_EN; 32'hFFFF_FFFF with it.
// - char_valid & eof_i in the same IDLE cycle -> the char is committed first (total_o+1),
//   then done_o=1; done_o drops the cycle after eof_i falls.

Source files
------------

// File: rtl/t05_hist_sram_client.sv
// t05_hist_sram_client
// Histogram-stage initiator for the SRAM request interface. Each accepted
// character is read from word {HIST_BASE, char}, incremented and written
// back. done_o is raised once eof_i is seen in IDLE. A responder that stalls
// a read or write handshake for TIMEOUT cycles parks the block in a sticky
// ERROR state.
// Build option: define T05_HIST_SAT_EN to make the increment saturate at
// all-ones instead of wrapping to zero.
module t05_hist_sram_client #(
  parameter logic [7:0] HIST_BASE = 8'h00,
  parameter int         DATA_W    = 32,
  parameter int         TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_i,
  input  logic              eof_i,
  output logic              char_ready,
  output logic              rd_en_o,
  output logic              wr_en_o,
  output logic [15:0]       addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              ready_i,
  input  logic              busy_i,
  output logic [31:0]       total_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_tcnt;
  logic [15:0]         r_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [31:0]         r_total;
  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_done;
  logic                w_error;
  logic                w_idle;
  logic                w_accept;
  logic                w_rd_hs;
  logic                w_wr_hs;
  logic                w_enter_req;

  // Count update applied to the word read back from SRAM.
  function automatic logic [DATA_W-1:0] f_inc(input logic [DATA_W-1:0] v);
`ifdef T05_HIST_SAT_EN
    if (&v) return v;
`endif
    return v + DATA_W'(1);
  endfunction

  assign w_idle      = (r_state == S_IDLE);
  assign w_accept    = w_idle & char_valid;
  assign w_rd_hs     = (r_state == S_READ) & ready_i;
  assign w_wr_hs     = (r_state == S_WRITE) & ~busy_i;
  assign w_enter_req = (w_state_nxt != r_state) &
                       ((w_state_nxt == S_READ) | (w_state_nxt == S_WRITE));

  // State register; reset parks the controller in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and request decoding; a char in IDLE wins over eof_i.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (char_valid)  w_state_nxt = S_READ;
        else if (eof_i)  w_state_nxt = S_DONE;
      end
      S_READ: begin
        w_rd_en = 1'b1;
        if (ready_i)                w_state_nxt = S_WRITE;
        else if (r_tcnt == TMO_LAST) w_state_nxt = S_ERROR;
      end
      S_WRITE: begin
        w_wr_en = 1'b1;
        if (!busy_i)                w_state_nxt = S_IDLE;
        else if (r_tcnt == TMO_LAST) w_state_nxt = S_ERROR;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (!eof_i) w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        w_error = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake wait counter: cleared on entry to READ/WRITE, counts stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_tcnt <= '0;
    else if (w_enter_req) r_tcnt <= '0;
    else if ((r_state == S_READ) || (r_state == S_WRITE)) r_tcnt <= r_tcnt + TW'(1);
  end

  // Address latch, incremented write data and committed-character count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wr_data <= '0;
      r_total   <= '0;
    end else begin
      if (w_accept) r_addr    <= {HIST_BASE, char_i};
      if (w_rd_hs)  r_wr_data <= f_inc(rd_data_i);
      if (w_wr_hs)  r_total   <= r_total + 32'd1;
    end
  end

  // char_ready is gated by rst so every output reads 0 while reset is held.
  assign char_ready = w_idle & ~rst;
  assign rd_en_o    = w_rd_en;
  assign wr_en_o    = w_wr_en;
  assign done_o     = w_done;
  assign error_o    = w_error;
  assign addr_o     = r_addr;
  assign wr_data_o  = r_wr_data;
  assign total_o    = r_total;

endmodule
